// File: rtl/hci_mem_bank_responder.sv
// HCI memory-bank responder: register-array bank behind one hci_mem port,
// always-grant or LFSR-stalled grant, 1-cycle response, saturating counters.
//
// Ports:
//   clk_i, rst_ni     clock, async active-low reset
//   clear_i           sync soft clear (valid, LFSR, counters)
//   req_i/gnt_o       request / combinational grant
//   add_i, wen_i      byte address, 1=read 0=write
//   be_i, data_i      byte enables, write data
//   user_i/r_user_o   ignored / tied 0
//   r_data_o          read data (held across writes)
//   r_valid_o         response, one cycle after each fire
//   n_reads_o         granted reads
//   n_writes_o        granted writes
//   n_stalls_o        cycles with req_i & ~gnt_o
module hci_mem_bank_responder #(
  parameter int unsigned DW        = 32,
  parameter int unsigned AW        = 32,
  parameter int unsigned BW        = 8,
  parameter int unsigned AWM       = 12,
  parameter int unsigned GNT_MODE  = 0,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned CNT_W     = 32
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               clear_i,
  input  logic               req_i,
  output logic               gnt_o,
  input  logic [AW-1:0]      add_i,
  input  logic               wen_i,
  input  logic [DW/BW-1:0]   be_i,
  input  logic [DW-1:0]      data_i,
  output logic [DW-1:0]      r_data_o,
  output logic               r_valid_o,
  input  logic               user_i,
  output logic               r_user_o,
  output logic [CNT_W-1:0]   n_reads_o,
  output logic [CNT_W-1:0]   n_writes_o,
  output logic [CNT_W-1:0]   n_stalls_o
);

  localparam int unsigned BEW = DW / BW;
  localparam int unsigned NW  = 1 << AWM;

  logic [DW-1:0]    mem_q [NW];
  logic [15:0]      lfsr_q, lfsr_d;
  logic             r_valid_q, r_valid_d;
  logic [DW-1:0]    r_data_q, r_data_d;
  logic [CNT_W-1:0] n_rd_q, n_rd_d;
  logic [CNT_W-1:0] n_wr_q, n_wr_d;
  logic [CNT_W-1:0] n_st_q, n_st_d;
  logic [AWM-1:0]   idx;
  logic             fire;
  logic             rd_fire;
  logic             wr_fire;
  logic             lfsr_fb;
  logic             unused_bits;

  assign unused_bits = ^{user_i, add_i[1:0], add_i[AW-1:AWM+2]};

  assign idx = add_i[AWM+1:2];

  generate
    if (GNT_MODE == 1) begin : g_rand
      assign gnt_o = req_i & (lfsr_q[1:0] != 2'b00);
    end else begin : g_always
      assign gnt_o = req_i;
    end
  endgenerate

  assign fire    = req_i & gnt_o;
  // A fire during clear is swallowed: no write, no response.
  assign rd_fire = fire & wen_i & ~clear_i;
  assign wr_fire = fire & ~wen_i & ~clear_i;

  // Fibonacci taps 16,14,13,11; steps only while a request is pending.
  assign lfsr_fb = lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10];

  function automatic logic [CNT_W-1:0] sat_inc(
    input logic [CNT_W-1:0] v,
    input logic             en
  );
    if (en && !(&v)) return v + 1'b1;
    return v;
  endfunction

  always_comb begin
    lfsr_d    = lfsr_q;
    r_valid_d = 1'b0;
    r_data_d  = r_data_q;
    n_rd_d    = n_rd_q;
    n_wr_d    = n_wr_q;
    n_st_d    = n_st_q;
    if (clear_i) begin
      lfsr_d = LFSR_SEED;
      n_rd_d = '0;
      n_wr_d = '0;
      n_st_d = '0;
    end else begin
      if (req_i) lfsr_d = {lfsr_q[14:0], lfsr_fb};
      r_valid_d = fire;
      if (rd_fire) r_data_d = mem_q[idx];
      n_rd_d = sat_inc(n_rd_q, rd_fire);
      n_wr_d = sat_inc(n_wr_q, wr_fire);
      n_st_d = sat_inc(n_st_q, req_i & ~gnt_o);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      lfsr_q    <= LFSR_SEED;
      r_valid_q <= 1'b0;
      r_data_q  <= '0;
      n_rd_q    <= '0;
      n_wr_q    <= '0;
      n_st_q    <= '0;
    end else begin
      lfsr_q    <= lfsr_d;
      r_valid_q <= r_valid_d;
      r_data_q  <= r_data_d;
      n_rd_q    <= n_rd_d;
      n_wr_q    <= n_wr_d;
      n_st_q    <= n_st_d;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int w = 0; w < int'(NW); w++) mem_q[w] <= '0;
    end else if (wr_fire) begin
      for (int k = 0; k < int'(BEW); k++) begin
        if (be_i[k]) mem_q[idx][k*BW +: BW] <= data_i[k*BW +: BW];
      end
    end
  end

  assign r_valid_o  = r_valid_q;
  assign r_data_o   = r_data_q;
  assign r_user_o   = 1'b0;
  assign n_reads_o  = n_rd_q;
  assign n_writes_o = n_wr_q;
  assign n_stalls_o = n_st_q;

endmodule
